// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 GPR file, one write-back port, two bypassed
// read ports (rs/rt), one unbypassed debug port, write counter.
//   clk, rst_n            : clock, synchronous active-low reset
//   wb_en/wb_addr/wb_data : write-back request
//   rs_*/rt_*             : combinational read ports with bypass
//   dbg_addr/dbg_data     : debug read of stored value only
//   wr_count              : committed non-r0 writes, wraps at 16 bits
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [15:0]       r_wr_count;

  logic w_wr_ok;
  logic w_byp_ok;
  logic w_byp_rs;
  logic w_byp_rt;

  // r0 is never written, so storage for it stays zero after reset.
  assign w_wr_ok  = wb_en && (wb_addr != '0);
  // Forwarding is off while reset is asserted: the write will not land.
  assign w_byp_ok = (BYPASS != 0) && wb_en && rst_n;
  assign w_byp_rs = w_byp_ok && (wb_addr == rs_addr);
  assign w_byp_rt = w_byp_ok && (wb_addr == rt_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_ok) begin
      r_regs[wb_addr] <= wb_data;
      r_wr_count      <= r_wr_count + 16'd1;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (w_byp_rs) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (w_byp_rt) begin
      rt_data = wb_data;
    end
  end

  always_comb begin
    dbg_data = r_regs[dbg_addr];
    if (dbg_addr == '0) begin
      dbg_data = '0;
    end
  end

  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed checks of reg_file_wb with bypass on
// and a second instance with bypass off sharing the same inputs.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data;
  logic [15:0] wr_count;
  logic [31:0] nb_rs_data, nb_rt_data, nb_dbg_data;
  logic [15:0] nb_wr_count;

  int errors = 0;
  int checks = 0;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rs_data(nb_rs_data),
    .rt_addr(rt_addr), .rt_data(nb_rt_data),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data),
    .wr_count(nb_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr(5'd5, 32'hDEADBEEF);
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (dbg_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL preload dbg got=%h exp=%h", dbg_data, 32'hDEADBEEF);
    end
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL reset rs got=%h exp=0", rs_data);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL reset dbg got=%h exp=0", dbg_data);
    end
    checks++;
    if (wr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset count got=%h exp=0", wr_count);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      rs_addr  = 5'(i);
      #1;
      checks++;
      if (dbg_data !== 32'h0 || rs_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_all a=%0d rs=%h dbg=%h exp=0",
                 i, rs_data, dbg_data);
      end
    end
  endtask

  task automatic test_basic;
    wr(5'd8, 32'h12345678);
    rs_addr = 5'd8;
    rt_addr = 5'd8;
    #1;
    checks++;
    if (rs_data !== 32'h12345678 || rt_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic rs=%h rt=%h exp=12345678", rs_data, rt_data);
    end
    checks++;
    if (wr_count !== 16'd1 || nb_wr_count !== 16'd1) begin
      errors++;
      $display("FAIL basic count got=%h/%h exp=1", wr_count, nb_wr_count);
    end
  endtask

  task automatic test_reg0;
    wb_en   = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'hFFFFFFFF;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL r0 bypass rs=%h rt=%h exp=0", rs_data, rt_data);
    end
    tick();
    wb_en    = 1'b0;
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (rs_data !== 32'h0 || dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL r0 after rs=%h dbg=%h exp=0", rs_data, dbg_data);
    end
    checks++;
    if (wr_count !== 16'd1) begin
      errors++;
      $display("FAIL r0 count got=%h exp=1", wr_count);
    end
  endtask

  task automatic test_bypass;
    wr(5'd9, 32'h1);
    wb_en    = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'hA5A5A5A5;
    rs_addr  = 5'd9;
    rt_addr  = 5'd9;
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass rs=%h rt=%h exp=a5a5a5a5", rs_data, rt_data);
    end
    checks++;
    if (dbg_data !== 32'h1) begin
      errors++;
      $display("FAIL bypass dbg got=%h exp=1", dbg_data);
    end
    checks++;
    if (nb_rs_data !== 32'h1 || nb_rt_data !== 32'h1) begin
      errors++;
      $display("FAIL nobypass rs=%h rt=%h exp=1", nb_rs_data, nb_rt_data);
    end
    rt_addr = 5'd8;
    #1;
    checks++;
    if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass split rs=%h rt=%h exp=a5a5a5a5/12345678",
               rs_data, rt_data);
    end
    tick();
    wb_en = 1'b0;
    #1;
    checks++;
    if (dbg_data !== 32'hA5A5A5A5 || nb_rs_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass after dbg=%h nbrs=%h exp=a5a5a5a5",
               dbg_data, nb_rs_data);
    end
    checks++;
    if (wr_count !== 16'd3) begin
      errors++;
      $display("FAIL bypass count got=%h exp=3", wr_count);
    end
  endtask

  task automatic test_reset_priority;
    rst_n    = 1'b0;
    wb_en    = 1'b1;
    wb_addr  = 5'd31;
    wb_data  = 32'h00400010;
    rs_addr  = 5'd31;
    dbg_addr = 5'd31;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL rst bypass rs got=%h exp=0", rs_data);
    end
    tick();
    rst_n = 1'b1;
    wb_en = 1'b0;
    #1;
    checks++;
    if (dbg_data !== 32'h0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL rst prio dbg=%h cnt=%h exp=0/0", dbg_data, wr_count);
    end
    wr(5'd31, 32'h00400010);
    #1;
    checks++;
    if (dbg_data !== 32'h00400010 || wr_count !== 16'd1) begin
      errors++;
      $display("FAIL link dbg=%h cnt=%h exp=00400010/1",
               dbg_data, wr_count);
    end
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    wb_en   = 1'b1;
    wb_addr = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      wb_data = 32'(i);
      tick();
    end
    checks++;
    if (wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap pre count got=%h exp=ffff", wr_count);
    end
    wb_data = 32'h0000FFFF;
    tick();
    wb_en    = 1'b0;
    dbg_addr = 5'd1;
    rs_addr  = 5'd1;
    #1;
    checks++;
    if (wr_count !== 16'h0) begin
      errors++;
      $display("FAIL wrap count got=%h exp=0", wr_count);
    end
    checks++;
    if (dbg_data !== 32'h0000FFFF || rs_data !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL wrap data dbg=%h rs=%h exp=0000ffff",
               dbg_data, rs_data);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    rs_addr  = '0;
    rt_addr  = '0;
    dbg_addr = '0;
    test_reset();
    test_basic();
    test_reg0();
    test_bypass();
    test_reset_priority();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
